// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, word-addressed instruction memory and IF/ID
// output register. Resolves unconditional jumps at fetch, accepts redirects
// from later stages and stops on HALT.
module if_stage #(
  parameter int unsigned AW       = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  input  logic          id_ready,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instruction,
  output logic [31:0]   pc_out,
  output logic          if_valid,
  output logic          halted,
  output logic [31:0]   pc
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] HALTED = 2'b10;

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [31:0] mem [2**AW];

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  logic [31:0] word;
  logic [31:0] pc_plus4;
  logic        adv;

  assign word     = mem[pc_q[AW+1:2]];
  assign pc_plus4 = pc_q + 32'd4;
  assign adv      = (state_q == RUN) && (!valid_q || id_ready);

  // Instruction-memory load port; blocked while fetching so the program
  // cannot change under the running PC. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (imem_we && (state_q != RUN)) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  // Next-state for the FSM, PC and IF/ID register in priority order:
  // redirect, stall, J, HALT, sequential fetch; drain when not running.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        pc_d    = redirect_pc & ~32'd3;
        valid_d = 1'b0;
      end else if (adv) begin
        instr_d  = word;
        pc_out_d = pc_plus4;
        valid_d  = 1'b1;
        if (word[31:26] == OP_J) begin
          pc_d = {pc_plus4[31:28], word[25:0], 2'b00};
        end else if (word[31:26] == OP_HALT) begin
          state_d = HALTED;
        end else begin
          pc_d = pc_plus4;
        end
      end
    end else begin
      if (id_ready) begin
        valid_d = 1'b0;
      end
      // start takes precedence over redirect here, which is simply ignored
      if (start) begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
    end
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == HALTED);
  assign pc          = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with hand-computed expected values.
module tb_if_stage;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          id_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   instruction;
  logic [31:0]   pc_out;
  logic          if_valid;
  logic          halted;
  logic [31:0]   pc;

  int vectors = 0;
  int miscompares = 0;

  if_stage #(.AW(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .pc_out(pc_out), .if_valid(if_valid),
    .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] po,
                         input logic v, input logic h, input logic [31:0] p);
    chk({tag, ".instruction"}, instruction, ins);
    chk({tag, ".pc_out"}, pc_out, po);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    chk({tag, ".pc"}, pc, p);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 rst = 1'b0;

    // basic program: three ordinary words then HALT
    wr(8'd0, 32'h0000_0020);
    wr(8'd1, 32'h0000_0022);
    wr(8'd2, 32'h0000_0024);
    wr(8'd3, 32'hFC00_0000);
    wr(8'd16, 32'h0000_0030);
    wr(8'd17, 32'hFC00_0000);
    wr(8'd32, 32'h0000_0040);
    wr(8'd33, 32'hFC00_0000);
    wr(8'd5, 32'h0000_0050);
    wr(8'd6, 32'hFC00_0000);
    wr(8'd255, 32'h0000_0064);
    chk_out("idle", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    pulse_start();
    chk_out("start", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); chk_out("seq0", 32'h0000_0020, 32'h4, 1'b1, 1'b0, 32'h4);
    tick(); chk_out("seq1", 32'h0000_0022, 32'h8, 1'b1, 1'b0, 32'h8);
    tick(); chk_out("seq2", 32'h0000_0024, 32'hC, 1'b1, 1'b0, 32'hC);
    tick(); chk_out("halt", 32'hFC00_0000, 32'h10, 1'b1, 1'b1, 32'hC);
    tick(); chk_out("drain", 32'hFC00_0000, 32'h10, 1'b0, 1'b1, 32'hC);
    tick(); chk_out("nofetch", 32'hFC00_0000, 32'h10, 1'b0, 1'b1, 32'hC);

    // J at word 1 targets 0x40 with no gap cycle
    wr(8'd1, 32'h0800_0010);
    pulse_start();
    chk_out("jstart", 32'hFC00_0000, 32'h10, 1'b0, 1'b0, 32'h0);
    tick(); chk_out("j0", 32'h0000_0020, 32'h4, 1'b1, 1'b0, 32'h4);
    tick(); chk_out("jinst", 32'h0800_0010, 32'h8, 1'b1, 1'b0, 32'h40);
    tick(); chk_out("jtgt", 32'h0000_0030, 32'h44, 1'b1, 1'b0, 32'h44);
    tick(); chk_out("jhalt", 32'hFC00_0000, 32'h48, 1'b1, 1'b1, 32'h44);

    // stall for three cycles, resume, then redirect during a stall
    wr(8'd1, 32'h0000_0022);
    pulse_start();
    tick(); chk_out("s0", 32'h0000_0020, 32'h4, 1'b1, 1'b0, 32'h4);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("stall", 32'h0000_0020, 32'h4, 1'b1, 1'b0, 32'h4);
    end
    id_ready = 1'b1;
    tick(); chk_out("resume", 32'h0000_0022, 32'h8, 1'b1, 1'b0, 32'h8);
    id_ready = 1'b0;
    tick(); chk_out("stall2", 32'h0000_0022, 32'h8, 1'b1, 1'b0, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0083;
    tick(); chk_out("redir", 32'h0000_0022, 32'h8, 1'b0, 1'b0, 32'h80);
    redirect_valid = 1'b0; id_ready = 1'b1;
    tick(); chk_out("rtgt", 32'h0000_0040, 32'h84, 1'b1, 1'b0, 32'h84);
    tick(); chk_out("rhalt", 32'hFC00_0000, 32'h88, 1'b1, 1'b1, 32'h84);

    // write in RUN is ignored; start beats redirect in HALTED
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    start = 1'b0;
    chk_out("startwins", 32'hFC00_0000, 32'h88, 1'b0, 1'b0, 32'h0);
    redirect_pc = 32'h0000_0014; imem_we = 1'b1; imem_waddr = 8'd5; imem_wdata = 32'h0000_DEAD;
    tick(); chk_out("r14", 32'hFC00_0000, 32'h88, 1'b0, 1'b0, 32'h14);
    redirect_valid = 1'b0; imem_we = 1'b0;
    tick(); chk_out("wrun", 32'h0000_0050, 32'h18, 1'b1, 1'b0, 32'h18);
    tick(); chk_out("w6", 32'hFC00_0000, 32'h1C, 1'b1, 1'b1, 32'h18);
    wr(8'd5, 32'h0000_0099);
    pulse_start();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0014;
    tick();
    redirect_valid = 1'b0;
    tick(); chk_out("whalt", 32'h0000_0099, 32'h18, 1'b1, 1'b0, 32'h18);

    // PC wraps modulo 2^32, then asynchronous reset mid-RUN
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); chk_out("rwrap", 32'h0000_0099, 32'h18, 1'b0, 1'b0, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick(); chk_out("wrap", 32'h0000_0064, 32'h0, 1'b1, 1'b0, 32'h0);
    id_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_out("arst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 rst = 1'b0;
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick(); chk_out("idle_redir", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    redirect_valid = 1'b0;
    tick(); tick(); chk_out("nostart", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
